// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush sequencer.
// E-stage mult/div start codes, exception vector and timer state type.
package pipe_ctrl_pkg;

    localparam logic [1:0]  MD_NONE    = 2'b00;
    localparam logic [1:0]  MD_MULT    = 2'b01;
    localparam logic [1:0]  MD_DIV     = 2'b10;
    localparam logic [31:0] PC_EXC_VEC = 32'h0000_4180;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } md_state_t;

    // The reserved code 2'b11 behaves as no operation.
    function automatic logic is_md_start(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/pipe_ctrl_md_busy_timer.sv
// Mult/div busy timer: tracks the latency of the md unit after a start.
// md_busy covers the start cycle plus N further cycles; md_done marks the last one.
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] e_md_op,
    input  logic       req,
    output logic       md_busy,
    output logic       md_done
);

    localparam int unsigned CW = $clog2(DIV_CYCLES + 1);

    md_state_t       state;
    md_state_t       state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    logic            start;

    // A request in the start cycle belongs to the faulting md instr, so it never issues.
    assign start = is_md_start(e_md_op) && !req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        md_busy    = 1'b0;
        md_done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    md_busy    = 1'b1;
                    state_next = S_BUSY;
                    cnt_next   = (e_md_op == MD_MULT) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end
            end
            S_BUSY: begin
                md_busy  = 1'b1;
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    md_done    = 1'b1;
                    state_next = S_IDLE;
                end
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer: merges data-hazard stall, md busy and CP0 request
// into PC/F-D enables and the D/E bubble, and counts stalled cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned PERF_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              raw_stall,
    input  logic [1:0]        e_md_op,
    input  logic              d_uses_md,
    input  logic              req,
    output logic              pc_en,
    output logic              d_en,
    output logic              e_flush,
    output logic              md_busy,
    output logic              md_done,
    output logic [PERF_W-1:0] stall_cnt
);

    logic stall;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_timer (
        .clk     (clk),
        .reset   (reset),
        .e_md_op (e_md_op),
        .req     (req),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    // On a request the pipeline registers flush through their own req path, so no stall here.
    assign stall   = !req && (raw_stall || (d_uses_md && md_busy));
    assign pc_en   = !stall;
    assign d_en    = !stall;
    assign e_flush = stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: cycle-level behavioural model plus directed literal checks.
module tb_pipe_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        raw_stall;
    logic [1:0]  e_md_op;
    logic        d_uses_md;
    logic        req;
    logic        pc_en, d_en, e_flush, md_busy, md_done;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_d_en, s_e_flush, s_md_busy, s_md_done;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    pipe_ctrl u_dut (
        .clk(clk), .reset(reset), .raw_stall(raw_stall), .e_md_op(e_md_op),
        .d_uses_md(d_uses_md), .req(req), .pc_en(pc_en), .d_en(d_en),
        .e_flush(e_flush), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
    );

    pipe_ctrl #(.PERF_W(4)) u_small (
        .clk(clk), .reset(reset), .raw_stall(raw_stall), .e_md_op(e_md_op),
        .d_uses_md(d_uses_md), .req(req), .pc_en(s_pc_en), .d_en(s_d_en),
        .e_flush(s_e_flush), .md_busy(s_md_busy), .md_done(s_md_done), .stall_cnt(s_stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: absolute cycle numbers; md unit busy through cycle md_end, unbounded stall count.
    int     cyc    = 0;
    int     md_end = -1;
    longint scount = 0;
    bit     live   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic busy_prior();
        return cyc <= md_end;
    endfunction

    function automatic logic starts_now();
        return !busy_prior() && (e_md_op == 2'b01 || e_md_op == 2'b10) && !req;
    endfunction

    function automatic logic stall_now();
        return !req && (raw_stall || (d_uses_md && (busy_prior() || starts_now())));
    endfunction

    function automatic longint sat(input longint v, input int w);
        longint m;
        m = (longint'(1) << w) - 1;
        return (v > m) ? m : v;
    endfunction

    always @(posedge clk) begin
        logic st, stl;
        st  = starts_now();
        stl = stall_now();
        if (reset) begin
            md_end = -1;
            scount = 0;
        end else begin
            if (st) md_end = cyc + ((e_md_op == 2'b01) ? MC : DC);
            if (stl) scount++;
        end
        cyc++;
        live = 1;
    end

    always @(negedge clk) begin
        logic eb, ed, es;
        if (live) begin
            eb = busy_prior() || starts_now();
            ed = busy_prior() && (cyc == md_end);
            es = stall_now();
            check("pc_en", pc_en, !es);
            check("d_en", d_en, !es);
            check("e_flush", e_flush, es);
            check("md_busy", md_busy, eb);
            check("md_done", md_done, ed);
            check("stall_cnt", stall_cnt, sat(scount, 16));
            check("small_busy", s_md_busy, eb);
            check("small_stall_cnt", s_stall_cnt, sat(scount, 4));
        end
    end

    task automatic tick(input logic r, input logic [1:0] op, input logic dum,
                        input logic rs, input logic rq);
        @(posedge clk);
        #1;
        reset     = r;
        e_md_op   = op;
        d_uses_md = dum;
        raw_stall = rs;
        req       = rq;
        @(negedge clk);
    endtask

    initial begin
        int busy_n, done_at;
        reset = 1'b1; raw_stall = 1'b0; e_md_op = 2'b00; d_uses_md = 1'b0; req = 1'b0;

        // Reset for two cycles, then idle.
        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("rst_pc_en", pc_en, 1);
        check("rst_d_en", d_en, 1);
        check("rst_e_flush", e_flush, 0);
        check("rst_md_busy", md_busy, 0);
        check("rst_stall_cnt", stall_cnt, 0);

        // Mult with dependent D-stage instruction: 6 busy and stalled cycles.
        tick(0, 2'b01, 1, 0, 0);
        check("mult_start_pc_en", pc_en, 0);
        check("mult_start_flush", e_flush, 1);
        busy_n = 1; done_at = -1;
        for (int k = 1; k <= 7; k++) begin
            tick(0, 2'b00, 1, 0, 0);
            if (md_busy) busy_n++;
            if (md_done) done_at = k;
        end
        check("mult_busy_cycles", busy_n, 6);
        check("mult_done_offset", done_at, 5);
        check("mult_stall_cnt", stall_cnt, 6);
        check("mult_after_pc_en", pc_en, 1);

        // Div without dependency; a second start mid-way is ignored.
        tick(0, 2'b10, 0, 0, 0);
        busy_n = 1; done_at = -1;
        for (int k = 1; k <= 12; k++) begin
            tick(0, (k == 5) ? 2'b10 : 2'b00, 0, 0, 0);
            if (md_busy) busy_n++;
            if (md_done) done_at = k;
        end
        check("div_busy_cycles", busy_n, 11);
        check("div_done_offset", done_at, 10);
        check("div_no_stall_cnt", stall_cnt, 6);

        // Request in the start cycle cancels the mult.
        tick(0, 2'b01, 1, 0, 1);
        check("req_start_pc_en", pc_en, 1);
        check("req_start_flush", e_flush, 0);
        tick(0, 2'b00, 0, 0, 0);
        check("req_start_busy_next", md_busy, 0);

        // Request while busy (cnt=3 at offset 3) does not abort.
        tick(0, 2'b01, 0, 0, 0);
        done_at = -1;
        for (int k = 1; k <= 7; k++) begin
            tick(0, 2'b00, 0, 0, (k == 3));
            if (k == 4) check("req_busy_continues", md_busy, 1);
            if (md_done) done_at = k;
        end
        check("req_busy_done_offset", done_at, 5);

        // Reset in the middle of a div (cnt=7 at offset 4).
        tick(0, 2'b10, 0, 0, 0);
        for (int k = 1; k <= 3; k++) tick(0, 2'b00, 0, 1, 0);
        tick(1, 2'b00, 0, 0, 0);
        tick(0, 2'b00, 0, 0, 0);
        check("rst_busy_abort", md_busy, 0);
        check("rst_busy_done", md_done, 0);
        check("rst_busy_stall_cnt", stall_cnt, 0);

        // Saturation of the 4-bit counter; request masks raw stall.
        for (int k = 0; k < 20; k++) tick(0, 2'b00, 0, 1, 0);
        tick(0, 2'b00, 0, 0, 0);
        check("sat_small", s_stall_cnt, 15);
        check("sat_big", stall_cnt, 20);
        tick(0, 2'b00, 0, 1, 1);
        check("req_raw_pc_en", pc_en, 1);
        check("req_raw_flush", e_flush, 0);
        tick(0, 2'b00, 0, 0, 0);
        check("req_raw_no_count", stall_cnt, 20);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            tick(($urandom_range(99) == 0),
                 2'($urandom_range(3)),
                 1'($urandom_range(1)),
                 ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
